blend_tile_scheduler: RTL and testbench

Sequencer that drives one `alpha_blend` datapath across a full tile. For each pixel in raster order it streams the sorted Gaussian list's per-pixel coefficients from the coefficient memory into the blender. It keeps only the final blended value per pixel and emits that value on a pixel output stream. Between pixels it clears the blender's accumulators with an isolated `end_of_tile` pulse.

---
 rtl/blend_sched_pkg.sv | 35 +++
 rtl/blend_coef_fifo.sv | 47 ++++
 rtl/blend_tile_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_blend_tile_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blend_sched_pkg.sv
// Shared types for the blend tile scheduler.
//   state_t  : sequencer states
//   coef_t   : one Gaussian's per-pixel coefficient set as read from memory
//   calc_*_w : index width derivations used for port and counter sizing
package blend_sched_pkg;

  // coef_t field width; the scheduler's DATA_WIDTH must match it.
  localparam int COEF_DW = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FLUSH,
    ZERO
  } state_t;

  typedef struct packed {
    logic [COEF_DW-1:0] a;
    logic [COEF_DW-1:0] b;
    logic [COEF_DW-1:0] c;
    logic [COEF_DW-1:0] d;
    logic [COEF_DW-1:0] opacity;
    logic [COEF_DW-1:0] color;
  } coef_t;

  function automatic int calc_pix_w(input int tile_size);
    return $clog2(tile_size * tile_size);
  endfunction

  function automatic int calc_idx_w(input int max_samples);
    return $clog2(max_samples);
  endfunction

endpackage

// File: rtl/blend_coef_fifo.sv
// Two-entry coefficient FIFO with fall-through when empty.
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write port (memory return data)
//   pop               : consume head; only legal while head_valid
//   head_valid, head  : current head, or the incoming word when empty
//   occ               : stored entries (0..2), excludes a same-cycle bypass
module blend_coef_fifo
  import blend_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  coef_t      push_data,
  input  logic       pop,
  output logic       head_valid,
  output coef_t      head,
  output logic [1:0] occ
);

  coef_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  bypass;

  // Empty FIFO: the returning word is presented directly so a read at t can
  // be consumed at t+1; if it is popped that cycle it is never stored.
  assign bypass     = push && pop && (occ == 2'd0);
  assign head_valid = (occ != 2'd0) || push;
  assign head       = (occ == 2'd0) ? push_data : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push && !bypass) wr_ptr <= ~wr_ptr;
      if (pop && occ != 2'd0) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bypass) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/blend_tile_scheduler.sv
// Drives one alpha_blend datapath across a tile in raster order.
// For each pixel: reads N coefficient sets (1-cycle memory), streams them to
// the blender, discards all but the last blended result, emits that on the
// pixel stream, then clears the blender with an isolated end_of_tile pulse.
// N == 0 emits a zero-valued pixel stream with no memory or blender traffic.
//   clk, rst                      : clock, synchronous active-high reset
//   start, num_gauss, busy, done  : tile control
//   coef_rd_* / coef_*            : coefficient memory read port and data
//   blend_* (out), blend_in_ready : blender input stream + accumulator clear
//   blend_out_valid/ready, result : blender output stream
//   pix_valid/ready/idx/value     : per-pixel result stream
module blend_tile_scheduler
  import blend_sched_pkg::*;
#(
  parameter int TILE_SIZE   = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_SAMPLES = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [calc_idx_w(MAX_SAMPLES):0]    num_gauss,
  output logic                                busy,
  output logic                                done,
  output logic                                coef_rd_en,
  output logic [calc_pix_w(TILE_SIZE)-1:0]    coef_rd_pix,
  output logic [calc_idx_w(MAX_SAMPLES)-1:0]  coef_rd_idx,
  input  logic [DATA_WIDTH-1:0]               coef_a,
  input  logic [DATA_WIDTH-1:0]               coef_b,
  input  logic [DATA_WIDTH-1:0]               coef_c,
  input  logic [DATA_WIDTH-1:0]               coef_d,
  input  logic [DATA_WIDTH-1:0]               coef_opacity,
  input  logic [DATA_WIDTH-1:0]               coef_color,
  output logic                                blend_in_valid,
  input  logic                                blend_in_ready,
  output logic                                blend_end_of_tile,
  output logic [DATA_WIDTH-1:0]               blend_a,
  output logic [DATA_WIDTH-1:0]               blend_b,
  output logic [DATA_WIDTH-1:0]               blend_c,
  output logic [DATA_WIDTH-1:0]               blend_d,
  output logic [DATA_WIDTH-1:0]               blend_opacity,
  output logic [DATA_WIDTH-1:0]               blend_color,
  input  logic                                blend_out_valid,
  output logic                                blend_out_ready,
  input  logic [DATA_WIDTH-1:0]               blend_result,
  output logic                                pix_valid,
  input  logic                                pix_ready,
  output logic [calc_pix_w(TILE_SIZE)-1:0]    pix_idx,
  output logic [DATA_WIDTH-1:0]               pix_value
);

  localparam int PIX_W = calc_pix_w(TILE_SIZE);
  localparam int IDX_W = calc_idx_w(MAX_SAMPLES);
  localparam int NPIX  = TILE_SIZE * TILE_SIZE;

  // p is one bit wider than a pixel index so NPIX itself is representable.
  localparam logic [PIX_W:0] NPIX_P = (PIX_W+1)'(NPIX);
  localparam logic [PIX_W:0] LAST_P = (PIX_W+1)'(NPIX - 1);
  localparam logic [PIX_W:0] ONE_P  = (PIX_W+1)'(1);
  localparam logic [IDX_W:0] ONE_I  = (IDX_W+1)'(1);

  state_t         state_q, state_d;
  logic [IDX_W:0] n_q;    // Gaussians per pixel
  logic [PIX_W:0] p_q;    // current pixel
  logic [IDX_W:0] ri_q;   // next read index
  logic [IDX_W:0] hs_q;   // blender input handshakes this pixel
  logic [IDX_W:0] r_q;    // blender results this pixel
  logic           rd_q;   // read in flight (data returns this cycle)
  logic           done_q;

  coef_t          rd_data;
  coef_t          head;
  logic           fifo_vld;
  logic [1:0]     occ;

  logic [PIX_W:0] p_inc;
  logic           res_phase;
  logic           last_res;
  logic           in_hs;
  logic           res_hs;
  logic           final_hs;
  logic           all_in;
  logic           credit_ok;

  assign rd_data = '{a: coef_a, b: coef_b, c: coef_c, d: coef_d,
                     opacity: coef_opacity, color: coef_color};

  blend_coef_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rd_q),
    .push_data  (rd_data),
    .pop        (in_hs),
    .head_valid (fifo_vld),
    .head       (head),
    .occ        (occ)
  );

  // At most two coefficient sets are ever owed to the FIFO, counting the
  // read whose data is returning this cycle.
  assign credit_ok = (occ + {1'b0, rd_q}) < 2'd2;

  assign p_inc     = p_q + ONE_P;
  assign res_phase = (state_q == ISSUE) || (state_q == DRAIN);
  assign last_res  = (r_q == n_q - ONE_I);

  // Only the last result of a pixel waits on the pixel stream; earlier
  // partial results are dropped as soon as they appear.
  assign blend_out_ready = res_phase && (!last_res || pix_ready);
  assign res_hs          = blend_out_valid && blend_out_ready;
  assign final_hs        = res_hs && last_res;

  assign blend_in_valid  = (state_q == ISSUE) && fifo_vld;
  assign in_hs           = blend_in_valid && blend_in_ready;
  assign all_in          = in_hs && (hs_q + ONE_I == n_q);

  assign blend_a       = blend_in_valid ? head.a       : '0;
  assign blend_b       = blend_in_valid ? head.b       : '0;
  assign blend_c       = blend_in_valid ? head.c       : '0;
  assign blend_d       = blend_in_valid ? head.d       : '0;
  assign blend_opacity = blend_in_valid ? head.opacity : '0;
  assign blend_color   = blend_in_valid ? head.color   : '0;

  assign coef_rd_pix = coef_rd_en ? p_q[PIX_W-1:0]  : '0;
  assign coef_rd_idx = coef_rd_en ? ri_q[IDX_W-1:0] : '0;

  assign pix_idx   = pix_valid ? p_q[PIX_W-1:0] : '0;
  assign pix_value = (pix_valid && res_phase) ? blend_result : '0;

  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    coef_rd_en        = 1'b0;
    blend_end_of_tile = 1'b0;
    pix_valid         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (num_gauss != '0) ? ISSUE : ZERO;
      end
      ISSUE: begin
        coef_rd_en = (ri_q < n_q) && credit_ok;
        pix_valid  = last_res && blend_out_valid;
        // Only a zero-latency blender can finish during the last issue.
        if (all_in) state_d = final_hs ? FLUSH : DRAIN;
      end
      DRAIN: begin
        pix_valid = last_res && blend_out_valid;
        if (final_hs) state_d = FLUSH;
      end
      FLUSH: begin
        blend_end_of_tile = 1'b1;
        state_d = (p_inc == NPIX_P) ? IDLE : ISSUE;
      end
      ZERO: begin
        pix_valid = 1'b1;
        if (pix_ready && p_q == LAST_P) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q    <= '0;
      p_q    <= '0;
      ri_q   <= '0;
      hs_q   <= '0;
      r_q    <= '0;
      rd_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rd_q   <= coef_rd_en;
      done_q <= ((state_q == FLUSH) && (p_inc == NPIX_P)) ||
                ((state_q == ZERO) && pix_ready && (p_q == LAST_P));
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q  <= num_gauss;
            p_q  <= '0;
            ri_q <= '0;
            hs_q <= '0;
            r_q  <= '0;
          end
        end
        ISSUE, DRAIN: begin
          if (coef_rd_en) ri_q <= ri_q + ONE_I;
          if (in_hs)      hs_q <= hs_q + ONE_I;
          if (res_hs)     r_q  <= r_q + ONE_I;
        end
        FLUSH: begin
          p_q  <= p_inc;
          ri_q <= '0;
          hs_q <= '0;
          r_q  <= '0;
        end
        ZERO: begin
          if (pix_ready) p_q <= p_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blend_tile_scheduler.sv
module tb_blend_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  num_gauss = '0;
  logic        busy, done, coef_rd_en;
  logic [7:0]  coef_rd_pix;
  logic [4:0]  coef_rd_idx;
  logic [31:0] coef_a = '0, coef_b = '0, coef_c = '0, coef_d = '0;
  logic [31:0] coef_opacity = '0, coef_color = '0;
  logic        blend_in_valid, blend_in_ready, blend_end_of_tile;
  logic [31:0] blend_a, blend_b, blend_c, blend_d, blend_opacity, blend_color;
  logic        blend_out_valid, blend_out_ready;
  logic [31:0] blend_result;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [7:0]  pix_idx;
  logic [31:0] pix_value;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  blend_tile_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .num_gauss(num_gauss),
    .busy(busy), .done(done),
    .coef_rd_en(coef_rd_en), .coef_rd_pix(coef_rd_pix), .coef_rd_idx(coef_rd_idx),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c), .coef_d(coef_d),
    .coef_opacity(coef_opacity), .coef_color(coef_color),
    .blend_in_valid(blend_in_valid), .blend_in_ready(blend_in_ready),
    .blend_end_of_tile(blend_end_of_tile),
    .blend_a(blend_a), .blend_b(blend_b), .blend_c(blend_c), .blend_d(blend_d),
    .blend_opacity(blend_opacity), .blend_color(blend_color),
    .blend_out_valid(blend_out_valid), .blend_out_ready(blend_out_ready),
    .blend_result(blend_result),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_idx(pix_idx), .pix_value(pix_value)
  );

  // Coefficient memory: color = pix*256 + idx; other fields tag it with a nibble.
  function automatic logic [31:0] col(input int px, input int ix);
    return 32'(px * 256 + ix);
  endfunction

  always @(posedge clk) begin
    if (coef_rd_en) begin
      coef_color   <= col(int'(coef_rd_pix), int'(coef_rd_idx));
      coef_a       <= {4'h1, col(int'(coef_rd_pix), int'(coef_rd_idx))[27:0]};
      coef_b       <= {4'h2, col(int'(coef_rd_pix), int'(coef_rd_idx))[27:0]};
      coef_c       <= {4'h3, col(int'(coef_rd_pix), int'(coef_rd_idx))[27:0]};
      coef_d       <= {4'h4, col(int'(coef_rd_pix), int'(coef_rd_idx))[27:0]};
      coef_opacity <= {4'h5, col(int'(coef_rd_pix), int'(coef_rd_idx))[27:0]};
    end
  end

  // Blender model: one result register, latency 1, result = last input color.
  logic        res_vld;
  logic [31:0] res_val;
  logic        in_knob = 1'b1;
  assign blend_in_ready  = in_knob && (!res_vld || blend_out_ready);
  assign blend_out_valid = res_vld;
  assign blend_result    = res_val;

  always @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
      res_val <= '0;
    end else if (blend_in_valid && blend_in_ready) begin
      res_vld <= 1'b1;
      res_val <= blend_color;
    end else if (res_vld && blend_out_ready) begin
      res_vld <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard state, reset at every tile start.
  int cur_n, exp_rd_pix, exp_rd_idx, exp_in_pix, exp_in_idx, exp_px;
  int rd_cnt, in_cnt, eot_cnt, pix_cnt, done_cnt, max_idx;
  bit hold;
  logic [7:0]  h_idx;
  logic [31:0] h_val;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("pix_hold_valid", pix_valid, 1'b1);
        chk("pix_hold_idx", pix_idx, h_idx);
        chk("pix_hold_value", pix_value, h_val);
      end
      hold  = pix_valid && !pix_ready;
      h_idx = pix_idx;
      h_val = pix_value;
      if (pix_valid && !pix_ready) chk("stall_out_ready", blend_out_ready, 1'b0);

      if (coef_rd_en) begin
        chk("rd_pix", coef_rd_pix, exp_rd_pix);
        chk("rd_idx", coef_rd_idx, exp_rd_idx);
        chk("rd_credit", (rd_cnt - in_cnt) < 2, 1'b1);
        if (int'(coef_rd_idx) > max_idx) max_idx = int'(coef_rd_idx);
        rd_cnt++;
        if (exp_rd_idx + 1 == cur_n) begin exp_rd_idx = 0; exp_rd_pix++; end
        else exp_rd_idx++;
      end

      if (blend_in_valid && blend_in_ready) begin
        chk("in_color", {blend_opacity, blend_color},
            {4'h5, col(exp_in_pix, exp_in_idx)[27:0], col(exp_in_pix, exp_in_idx)});
        chk("in_ab", {blend_a, blend_b},
            {4'h1, col(exp_in_pix, exp_in_idx)[27:0], 4'h2, col(exp_in_pix, exp_in_idx)[27:0]});
        chk("in_cd", {blend_c, blend_d},
            {4'h3, col(exp_in_pix, exp_in_idx)[27:0], 4'h4, col(exp_in_pix, exp_in_idx)[27:0]});
        in_cnt++;
        if (exp_in_idx + 1 == cur_n) begin exp_in_idx = 0; exp_in_pix++; end
        else exp_in_idx++;
      end

      if (blend_end_of_tile) begin
        chk("eot_isolated", blend_in_valid, 1'b0);
        chk("eot_no_pending", res_vld, 1'b0);
        chk("eot_after_inputs", in_cnt, (eot_cnt + 1) * cur_n);
        chk("eot_after_pixel", pix_cnt, eot_cnt + 1);
        eot_cnt++;
      end

      if (pix_valid && pix_ready) begin
        chk("pix_idx", pix_idx, exp_px);
        chk("pix_value", pix_value, (cur_n == 0) ? 32'h0 : col(exp_px, cur_n - 1));
        exp_px++;
        pix_cnt++;
      end

      if (done) begin
        done_cnt++;
        chk("done_busy_low", busy, 1'b0);
        chk("done_after_last_pix", pix_cnt, 256);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_tile(input int n);
    cur_n = n; exp_rd_pix = 0; exp_rd_idx = 0; exp_in_pix = 0; exp_in_idx = 0;
    exp_px = 0; rd_cnt = 0; in_cnt = 0; eot_cnt = 0; pix_cnt = 0; done_cnt = 0;
    max_idx = 0; hold = 1'b0;
    pix_ready = 1'b1; in_knob = 1'b1;
    num_gauss = 6'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("first_rd_en", coef_rd_en, n > 0);
    chk("first_rd_pix", coef_rd_pix, 8'd0);
    chk("first_rd_idx", coef_rd_idx, 5'd0);
    if (n == 0) chk("zero_pix_valid", pix_valid, 1'b1);
  endtask

  task automatic finish_tile(input int n, input bit alt, input int stall_pix, input bit dbl);
    int cyc = 0;
    int stall = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      in_knob   = alt ? (cyc % 2 == 0) : 1'b1;
      pix_ready = 1'b1;
      if (stall_pix >= 0 && pix_valid && int'(pix_idx) == stall_pix && stall < 10) begin
        pix_ready = 1'b0;
        stall++;
      end
      start     = dbl && (cyc == 3);
      num_gauss = start ? 6'd7 : 6'(n);
      tick();
      cyc++;
    end
    start = 1'b0; in_knob = 1'b1; pix_ready = 1'b1;
    chk("tile_timeout", cyc < 20000, 1'b1);
    repeat (3) tick();
    chk("done_count", done_cnt, 1);
    chk("busy_idle", busy, 1'b0);
    chk("pix_count", pix_cnt, 256);
    chk("in_count", in_cnt, 256 * n);
    chk("rd_count", rd_cnt, 256 * n);
    chk("eot_count", eot_cnt, (n > 0) ? 256 : 0);
    chk("max_rd_idx", max_idx, (n > 0) ? n - 1 : 0);
    if (stall_pix >= 0) chk("stall_len", stall, 10);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd_en"}, {coef_rd_en, coef_rd_pix, coef_rd_idx}, '0);
    chk({tag, "_blend_in"}, {blend_in_valid, blend_end_of_tile, blend_color, blend_a}, '0);
    chk({tag, "_out_ready"}, blend_out_ready, 1'b0);
    chk({tag, "_pix"}, {pix_valid, pix_idx, pix_value}, '0);
  endtask

  initial begin
    repeat (3) tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();

    // Baseline tile.
    begin_tile(3);
    finish_tile(3, 1'b0, -1, 1'b0);

    // Alternating blender input backpressure.
    begin_tile(4);
    finish_tile(4, 1'b1, -1, 1'b0);

    // Pixel stream stall at pixel 5.
    begin_tile(2);
    finish_tile(2, 1'b0, 5, 1'b0);

    // Empty Gaussian list.
    begin_tile(0);
    finish_tile(0, 1'b0, -1, 1'b0);

    // Mid-tile reset during pixel 10, then restart.
    begin_tile(5);
    begin
      int w = 0;
      while (!(coef_rd_en && coef_rd_pix == 8'd10) && w < 5000) begin
        tick();
        w++;
      end
      chk("reach_pix10", w < 5000, 1'b1);
    end
    rst = 1'b1;
    tick();
    chk_quiet("midreset");
    rst = 1'b0;
    tick();
    chk("midreset_idle", busy, 1'b0);
    chk("midreset_no_done", done_cnt, 0);
    begin_tile(5);
    finish_tile(5, 1'b0, -1, 1'b0);

    // Maximum list length with a start pulse while busy.
    begin_tile(32);
    finish_tile(32, 1'b0, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
